// File: rtl/dcache_fill_fsm.sv
// Data-cache miss fill engine: fetches one block word by word, writes the data array, then the tag.
// Optional completed-fill counter output enabled by defining DCACHE_FILL_PERF_CNT_EN.
module dcache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] cache_word_addr,
    output logic        write_tag_array,
    output logic [15:0] fill_block_addr
`ifdef DCACHE_FILL_PERF_CNT_EN
    ,
    output logic [15:0] fill_count
`endif
);

    localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W = IDX_W + 1;
    // 16-bit words: one extra byte-offset bit below the word index
    localparam int unsigned OFF_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0
        || MEM_LATENCY == 0) begin : g_bad_cfg
        $error("dcache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2, MEM_LATENCY >= 1");
    end

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
    logic [15:0]      base_q, base_d;

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_word_addr  = '0;
        write_tag_array  = 1'b0;
        fill_block_addr  = base_q;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d      = {miss_address[15:OFF_W], {OFF_W{1'b0}}};
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                fsm_busy        = 1'b1;
                memory_address  = base_q | 16'({issue_cnt_q[IDX_W-1:0], 1'b0});
                cache_word_addr = base_q | 16'({recv_cnt_q[IDX_W-1:0], 1'b0});
                if (issue_cnt_q < CNT_FULL) begin
                    mem_read_en = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end
                // Issue and receive run independently; completion is set by returned words only.
                if (memory_data_valid && (recv_cnt_q < CNT_FULL)) begin
                    write_data_array = 1'b1;
                    recv_cnt_d       = recv_cnt_q + CNT_ONE;
                    if (recv_cnt_q == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

`ifdef DCACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count_q, fill_count_d;

    always_comb begin
        fill_count_d = fill_count_q;
        if (write_tag_array && (fill_count_q != '1)) begin
            fill_count_d = fill_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count_q <= '0;
        end else begin
            fill_count_q <= fill_count_d;
        end
    end

    assign fill_count = fill_count_q;
`else
    // memory_data is written by the array directly; the engine only sequences it.
    logic unused_data;
    assign unused_data = ^memory_data;
`endif

`ifdef DCACHE_FILL_PERF_CNT_EN
    logic unused_data_perf;
    assign unused_data_perf = ^memory_data;
`endif

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Directed bench for dcache_fill_fsm with a 4-cycle-latency memory model returning 16'hA000+word.
// Also checks fill_count when DCACHE_FILL_PERF_CNT_EN is defined.
module tb_dcache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] cache_word_addr;
    logic        write_tag_array;
    logic [15:0] fill_block_addr;
`ifdef DCACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count;
`endif

    dcache_fill_fsm #(
        .WORDS_PER_BLOCK(8),
        .MEM_LATENCY    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .cache_word_addr  (cache_word_addr),
        .write_tag_array  (write_tag_array),
        .fill_block_addr  (fill_block_addr)
`ifdef DCACHE_FILL_PERF_CNT_EN
        ,
        .fill_count       (fill_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned wr_seen;
    int unsigned tag_seen;

    // memory return pipeline, stage 3 drives the DUT
    bit          pv[4];
    logic [15:0] pd[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called mid-cycle: records this cycle's issue, advances one clock, returns mid-cycle.
    task automatic step();
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = (mem_read_en === 1'b1);
        pd[0] = 16'hA000 + {13'b0, memory_address[3:1]};
        @(posedge clk);
        #1;
        memory_data_valid = pv[3];
        memory_data       = pd[3];
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input logic [15:0] base);
        check({tag, ".busy"}, 32'(fsm_busy), 32'd0);
        check({tag, ".rd"}, 32'(mem_read_en), 32'd0);
        check({tag, ".wr"}, 32'(write_data_array), 32'd0);
        check({tag, ".tag"}, 32'(write_tag_array), 32'd0);
        check({tag, ".maddr"}, 32'(memory_address), 32'd0);
        check({tag, ".caddr"}, 32'(cache_word_addr), 32'd0);
        check({tag, ".base"}, 32'(fill_block_addr), 32'(base));
    endtask

    // k = cycles since the cycle in which the miss was presented
    task automatic check_fill(input int k, input logic [15:0] base);
        bit rd;
        bit wr;
        rd = (k >= 1 && k <= 8);
        wr = (k >= 5 && k <= 12);
        check($sformatf("busy@%0d", k), 32'(fsm_busy), 32'(k >= 1 && k <= 12));
        check($sformatf("rd@%0d", k), 32'(mem_read_en), 32'(rd));
        if (rd) check($sformatf("maddr@%0d", k), 32'(memory_address), 32'(base + 16'(2 * (k - 1))));
        check($sformatf("wr@%0d", k), 32'(write_data_array), 32'(wr));
        if (wr) begin
            check($sformatf("caddr@%0d", k), 32'(cache_word_addr), 32'(base + 16'(2 * (k - 5))));
            check($sformatf("data@%0d", k), 32'(memory_data), 32'(16'hA000 + 16'(k - 5)));
        end
        check($sformatf("tag@%0d", k), 32'(write_tag_array), 32'(k == 12));
        check($sformatf("base@%0d", k), 32'(fill_block_addr), 32'(base));
        wr_seen  += 32'(write_data_array);
        tag_seen += 32'(write_tag_array);
    endtask

    // Presents a miss in the current cycle and checks the 12 fill cycles.
    task automatic do_fill(input logic [15:0] addr, input logic [15:0] base, input bit inject);
        miss_detected = 1'b1;
        miss_address  = addr;
        wr_seen  = 0;
        tag_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            miss_detected = inject && (k == 3);
            if (inject && k == 3) miss_address = 16'h4000;
            check_fill(k, base);
        end
        check($sformatf("nwr %0h", addr), 32'(wr_seen), 32'd8);
        check($sformatf("ntag %0h", addr), 32'(tag_seen), 32'd1);
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data_valid = 1'b0;
        memory_data       = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end

        step();
        step();
        rst = 1'b0;
        check_idle("rst", 16'h0000);
`ifdef DCACHE_FILL_PERF_CNT_EN
        check("cnt.rst", 32'(fill_count), 32'd0);
`endif
        step();
        check_idle("idle", 16'h0000);

        // fill aborted by reset in its sixth cycle
        miss_detected = 1'b1;
        miss_address  = 16'h3456;
        for (int k = 1; k <= 6; k++) begin
            step();
            miss_detected = 1'b0;
            check_fill(k, 16'h3450);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("abort", 16'h0000);
        for (int j = 0; j < 6; j++) begin
            step();
            check($sformatf("post.wr%0d", j), 32'(write_data_array), 32'd0);
            check($sformatf("post.tag%0d", j), 32'(write_tag_array), 32'd0);
            check($sformatf("post.busy%0d", j), 32'(fsm_busy), 32'd0);
        end

        // miss with a second miss injected mid-fill, then back-to-back fills
        do_fill(16'h1236, 16'h1230, 1'b1);
        step();
        check_idle("end1", 16'h1230);
        do_fill(16'h2000, 16'h2000, 1'b0);
        step();
        check_idle("end2", 16'h2000);
        do_fill(16'hFFFE, 16'hFFF0, 1'b0);
        step();
        check_idle("end3", 16'hFFF0);
`ifdef DCACHE_FILL_PERF_CNT_EN
        check("cnt.3", 32'(fill_count), 32'd3);
`endif

        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst2", 16'h0000);
`ifdef DCACHE_FILL_PERF_CNT_EN
        check("cnt.clr", 32'(fill_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
